// File: rtl/rggen_register_access_driver.sv
// rggen_register_access_driver
//
// Register-side access driver for one register. It accepts a single bus
// request, decodes it against ADDRESS and issues one bit-field access
// strobe with registered read/write masks and write data. It then
// returns read data and status on a valid/ready response channel.
//
// Optional feature macro: RGGEN_ACCESS_DRIVER_WAIT_EN
//   When defined, adds i_field_ready. The ACCESS state then holds the
//   field strobe until the fields accept it.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req_*                 request channel (valid/ready, address, write, data, strobe)
//   o_rsp_*                 response channel (valid/ready, read data, status)
//   o_field_*               bit-field access (valid, read/write masks, write data)
//   i_field_read_data       combinational read data from the fields
//   i_field_ready           (WAIT_EN only) field access accepted
module rggen_register_access_driver #(
    parameter int                       ADDRESS_WIDTH = 8,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] ADDRESS       = '0,
    parameter bit                       READABLE      = 1'b1,
    parameter bit                       WRITABLE      = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_req_address,
    input  logic                    i_req_write,
    input  logic [DATA_WIDTH-1:0]   i_req_write_data,
    input  logic [DATA_WIDTH/8-1:0] i_req_strobe,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_read_data,
    output logic [1:0]              o_rsp_status,
    output logic                    o_field_valid,
    output logic [DATA_WIDTH-1:0]   o_field_read_mask,
    output logic [DATA_WIDTH-1:0]   o_field_write_mask,
    output logic [DATA_WIDTH-1:0]   o_field_write_data,
`ifdef RGGEN_ACCESS_DRIVER_WAIT_EN
    input  logic                    i_field_ready,
`endif
    input  logic [DATA_WIDTH-1:0]   i_field_read_data
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    // Byte-offset bits inside the register are don't-care for the decode.
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = {ADDRESS_WIDTH{1'b1}} << LSB;

    localparam logic [1:0] STATUS_OKAY   = 2'b00;
    localparam logic [1:0] STATUS_SLVERR = 2'b10;
    localparam logic [1:0] STATUS_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPONSE
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] expand_strobe(input logic [STRB_W-1:0] strobe);
        logic [DATA_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < STRB_W; i++) begin
            mask[8*i+:8] = {8{strobe[i]}};
        end
        return mask;
    endfunction

    state_t state;
    logic   write_q;
    logic   hit;
    logic   permitted;
    logic   access_done;

    assign hit       = ((i_req_address ^ ADDRESS) & ADDR_MASK) == '0;
    assign permitted = i_req_write ? WRITABLE : READABLE;

`ifdef RGGEN_ACCESS_DRIVER_WAIT_EN
    assign access_done = i_field_ready;
`else
    assign access_done = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state              <= IDLE;
            write_q            <= 1'b0;
            o_req_ready        <= 1'b1;
            o_rsp_valid        <= 1'b0;
            o_rsp_read_data    <= '0;
            o_rsp_status       <= STATUS_OKAY;
            o_field_valid      <= 1'b0;
            o_field_read_mask  <= '0;
            o_field_write_mask <= '0;
            o_field_write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        write_q     <= i_req_write;
                        o_req_ready <= 1'b0;
                        if (hit && permitted) begin
                            state              <= ACCESS;
                            o_field_valid      <= 1'b1;
                            o_field_read_mask  <= i_req_write ? '0 : '1;
                            o_field_write_mask <= i_req_write ? expand_strobe(i_req_strobe) : '0;
                            o_field_write_data <= i_req_write_data;
                        end else begin
                            // Rejected requests skip the field access entirely.
                            state           <= RESPONSE;
                            o_rsp_valid     <= 1'b1;
                            o_rsp_status    <= hit ? STATUS_SLVERR : STATUS_DECERR;
                            o_rsp_read_data <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (access_done) begin
                        // Sampled on the closing edge: value before any read side effect.
                        state              <= RESPONSE;
                        o_field_valid      <= 1'b0;
                        o_field_read_mask  <= '0;
                        o_field_write_mask <= '0;
                        o_rsp_valid        <= 1'b1;
                        o_rsp_status       <= STATUS_OKAY;
                        o_rsp_read_data    <= write_q ? '0 : i_field_read_data;
                    end
                end
                RESPONSE: begin
                    if (i_rsp_ready) begin
                        state           <= IDLE;
                        o_rsp_valid     <= 1'b0;
                        o_rsp_status    <= STATUS_OKAY;
                        o_rsp_read_data <= '0;
                        o_req_ready     <= 1'b1;
                    end
                end
                default: begin
                    state              <= IDLE;
                    o_req_ready        <= 1'b1;
                    o_rsp_valid        <= 1'b0;
                    o_field_valid      <= 1'b0;
                    o_field_read_mask  <= '0;
                    o_field_write_mask <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rggen_register_access_driver.sv
module tb_rggen_register_access_driver;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        ro_req_valid;
    logic [7:0]  req_address;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_strobe;
    logic        rsp_ready;
    logic [31:0] field_rd;
`ifdef RGGEN_ACCESS_DRIVER_WAIT_EN
    logic        field_ready;
`endif

    logic        req_ready, rsp_valid, fvalid;
    logic [31:0] rsp_rdata, rmask, wmask, fwdata;
    logic [1:0]  rsp_status;

    logic        ro_req_ready, ro_rsp_valid, ro_fvalid;
    logic [31:0] ro_rsp_rdata, ro_rmask, ro_wmask, ro_fwdata;
    logic [1:0]  ro_rsp_status;

    int tests = 0;
    int fails = 0;

    rggen_register_access_driver #(
        .ADDRESS_WIDTH(8), .DATA_WIDTH(32), .ADDRESS(8'h10), .READABLE(1'b1), .WRITABLE(1'b1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_address(req_address), .i_req_write(req_write),
        .i_req_write_data(req_wdata), .i_req_strobe(req_strobe),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_read_data(rsp_rdata), .o_rsp_status(rsp_status),
        .o_field_valid(fvalid), .o_field_read_mask(rmask),
        .o_field_write_mask(wmask), .o_field_write_data(fwdata),
`ifdef RGGEN_ACCESS_DRIVER_WAIT_EN
        .i_field_ready(field_ready),
`endif
        .i_field_read_data(field_rd)
    );

    rggen_register_access_driver #(
        .ADDRESS_WIDTH(8), .DATA_WIDTH(32), .ADDRESS(8'h10), .READABLE(1'b1), .WRITABLE(1'b0)
    ) dut_ro (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(ro_req_valid), .o_req_ready(ro_req_ready),
        .i_req_address(req_address), .i_req_write(req_write),
        .i_req_write_data(req_wdata), .i_req_strobe(req_strobe),
        .o_rsp_valid(ro_rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_read_data(ro_rsp_rdata), .o_rsp_status(ro_rsp_status),
        .o_field_valid(ro_fvalid), .o_field_read_mask(ro_rmask),
        .o_field_write_mask(ro_wmask), .o_field_write_data(ro_fwdata),
`ifdef RGGEN_ACCESS_DRIVER_WAIT_EN
        .i_field_ready(field_ready),
`endif
        .i_field_read_data(field_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for exactly one edge; returns just after that edge.
    task automatic send(input bit to_ro, input logic [7:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] s);
        req_address = a;
        req_write   = w;
        req_wdata   = d;
        req_strobe  = s;
        if (to_ro) ro_req_valid = 1'b1;
        else       req_valid    = 1'b1;
        tick();
        req_valid    = 1'b0;
        ro_req_valid = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        ro_req_valid = 1'b0;
        req_address  = '0;
        req_write    = 1'b0;
        req_wdata    = '0;
        req_strobe   = '0;
        rsp_ready    = 1'b1;
        field_rd     = '0;
`ifdef RGGEN_ACCESS_DRIVER_WAIT_EN
        field_ready  = 1'b1;
`endif

        // Reset and idle
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_field_valid", {31'd0, fvalid}, 32'd0);
        check("rst_status", {30'd0, rsp_status}, 32'd0);
        check("rst_wdata", fwdata, 32'd0);
        tick();

        // Read hit
        field_rd = 32'h0000_00A5;
        send(1'b0, 8'h10, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        check("rd_field_valid", {31'd0, fvalid}, 32'd1);
        check("rd_read_mask", rmask, 32'hFFFF_FFFF);
        check("rd_write_mask", wmask, 32'h0);
        check("rd_req_ready", {31'd0, req_ready}, 32'd0);
        check("rd_no_early_rsp", {31'd0, rsp_valid}, 32'd0);
        tick();
        @(negedge clk);
        check("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rd_rdata", rsp_rdata, 32'h0000_00A5);
        check("rd_status", {30'd0, rsp_status}, 32'd0);
        check("rd_fv_drop", {31'd0, fvalid}, 32'd0);
        check("rd_rmask_drop", rmask, 32'h0);
        tick();
        @(negedge clk);
        check("rd_rsp_done", {31'd0, rsp_valid}, 32'd0);
        check("rd_idle_ready", {31'd0, req_ready}, 32'd1);
        tick();

        // Read of a field that reads back all ones
        field_rd = 32'hFFFF_FFFF;
        send(1'b0, 8'h10, 1'b0, 32'h0, 4'h0);
        tick();
        @(negedge clk);
        check("rd1_rdata", rsp_rdata, 32'hFFFF_FFFF);
        tick();

        // Write with sparse strobe
        field_rd = 32'hDEAD_BEEF;
        send(1'b0, 8'h10, 1'b1, 32'h1234_5678, 4'b0101);
        @(negedge clk);
        check("wr_field_valid", {31'd0, fvalid}, 32'd1);
        check("wr_write_mask", wmask, 32'h00FF_00FF);
        check("wr_write_data", fwdata, 32'h1234_5678);
        check("wr_read_mask", rmask, 32'h0);
        tick();
        @(negedge clk);
        check("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("wr_rdata_zero", rsp_rdata, 32'h0);
        check("wr_status", {30'd0, rsp_status}, 32'd0);
        check("wr_wmask_drop", wmask, 32'h0);
        tick();

        // Write, zero strobe, unaligned byte offset still hits
        send(1'b0, 8'h13, 1'b1, 32'hAAAA_5555, 4'b0000);
        @(negedge clk);
        check("wz_field_valid", {31'd0, fvalid}, 32'd1);
        check("wz_write_mask", wmask, 32'h0);
        tick();
        @(negedge clk);
        check("wz_status", {30'd0, rsp_status}, 32'd0);
        check("wz_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        tick();

        // Miss -> DECERR one cycle after acceptance
        send(1'b0, 8'h14, 1'b0, 32'h7777_7777, 4'hF);
        @(negedge clk);
        check("miss_field_valid", {31'd0, fvalid}, 32'd0);
        check("miss_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("miss_status", {30'd0, rsp_status}, 32'd3);
        check("miss_rdata", rsp_rdata, 32'h0);
        check("miss_wdata_held", fwdata, 32'hAAAA_5555);
        tick();
        @(negedge clk);
        check("miss_done", {31'd0, rsp_valid}, 32'd0);
        tick();

        // Non-writable register: write -> SLVERR, read still works
        send(1'b1, 8'h10, 1'b1, 32'h1111_2222, 4'hF);
        @(negedge clk);
        check("ro_wr_field_valid", {31'd0, ro_fvalid}, 32'd0);
        check("ro_wr_rsp_valid", {31'd0, ro_rsp_valid}, 32'd1);
        check("ro_wr_status", {30'd0, ro_rsp_status}, 32'd2);
        check("ro_wr_rdata", ro_rsp_rdata, 32'h0);
        tick();
        field_rd = 32'h0000_3C3C;
        send(1'b1, 8'h10, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        check("ro_rd_field_valid", {31'd0, ro_fvalid}, 32'd1);
        tick();
        @(negedge clk);
        check("ro_rd_rdata", ro_rsp_rdata, 32'h0000_3C3C);
        check("ro_rd_status", {30'd0, ro_rsp_status}, 32'd0);
        tick();

        // Response back-pressure with a competing request
        rsp_ready = 1'b0;
        field_rd  = 32'h0000_005A;
        send(1'b0, 8'h10, 1'b0, 32'h0, 4'h0);
        tick();
        field_rd    = 32'h0;
        req_address = 8'h10;
        req_write   = 1'b1;
        req_wdata   = 32'h0BAD_F00D;
        req_strobe  = 4'hF;
        req_valid   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_rsp_valid_%0d", i), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("bp_rdata_%0d", i), rsp_rdata, 32'h0000_005A);
            check($sformatf("bp_req_ready_%0d", i), {31'd0, req_ready}, 32'd0);
            check($sformatf("bp_no_access_%0d", i), {31'd0, fvalid}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_rsp_drop", {31'd0, rsp_valid}, 32'd0);
        check("bp_ready_back", {31'd0, req_ready}, 32'd1);
        check("bp_not_yet_accepted", {31'd0, fvalid}, 32'd0);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("bp_accept_fv", {31'd0, fvalid}, 32'd1);
        check("bp_accept_wmask", wmask, 32'hFFFF_FFFF);
        check("bp_accept_wdata", fwdata, 32'h0BAD_F00D);
        tick();
        tick();

        // Asynchronous reset during ACCESS
        field_rd = 32'h0000_00C3;
        send(1'b0, 8'h10, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        check("ar_in_access", {31'd0, fvalid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_fv", {31'd0, fvalid}, 32'd0);
        check("ar_rmask", rmask, 32'h0);
        check("ar_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("ar_req_ready", {31'd0, req_ready}, 32'd1);
        check("ar_wdata", fwdata, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("ar_no_rsp_%0d", i), {31'd0, rsp_valid}, 32'd0);
            check($sformatf("ar_no_fv_%0d", i), {31'd0, fvalid}, 32'd0);
            tick();
        end

`ifdef RGGEN_ACCESS_DRIVER_WAIT_EN
        // Field not ready for 3 cycles -> strobe held 4 cycles
        field_ready = 1'b0;
        field_rd    = 32'h0000_0099;
        send(1'b0, 8'h10, 1'b0, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("wait_fv_%0d", i), {31'd0, fvalid}, 32'd1);
            check($sformatf("wait_no_rsp_%0d", i), {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        field_ready = 1'b1;
        @(negedge clk);
        check("wait_fv_3", {31'd0, fvalid}, 32'd1);
        tick();
        @(negedge clk);
        check("wait_fv_drop", {31'd0, fvalid}, 32'd0);
        check("wait_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("wait_rdata", rsp_rdata, 32'h0000_0099);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rggen_register_access_driver.md
Name: rggen_register_access_driver

Overview:
Register-side driver for a single register's bit-field access interface. It accepts one bus request at a time over a valid/ready handshake, decodes it against the register address, and issues a single-cycle bit-field access (valid, read_mask, write_mask, write_data). It then returns read data and status over a valid/ready response channel. It sits between a bus adapter and bit-field instances such as rggen_bit_field_w01crs_wcrs.

Parameters:
ADDRESS_WIDTH, 8, request address width in bits
DATA_WIDTH, 32, register/bus data width; multiple of 8, at least 8
ADDRESS, 0, byte address of this register; must be DATA_WIDTH/8 aligned
READABLE, 1, 0 makes reads return SLVERR with no field access
WRITABLE, 1, 0 makes writes return SLVERR with no field access

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_req_valid  input  1  request valid
o_req_ready  output  1  request accepted when high with i_req_valid
i_req_address  input  ADDRESS_WIDTH  byte address
i_req_write  input  1  1 = write, 0 = read
i_req_write_data  input  DATA_WIDTH  write data
i_req_strobe  input  DATA_WIDTH/8  byte enables, writes only
o_rsp_valid  output  1  response valid
i_rsp_ready  input  1  response consumed
o_rsp_read_data  output  DATA_WIDTH  read data; 0 for writes and errors
o_rsp_status  output  2  00 OKAY, 10 SLVERR, 11 DECERR
o_field_valid  output  1  bit-field access strobe
o_field_read_mask  output  DATA_WIDTH  all ones on read access, else 0
o_field_write_mask  output  DATA_WIDTH  strobe expanded per byte on write, else 0
o_field_write_data  output  DATA_WIDTH  captured write data
i_field_read_data  input  DATA_WIDTH  combinational read data from fields

Behaviour:
- Reset is asynchronous and active-low. Clock is i_clk, reset is i_rst_n, single clock domain.
- At reset: state IDLE, o_req_ready=1, every other output 0, all capture registers 0.
- FSM states are IDLE, ACCESS and RESPONSE.
- IDLE: o_req_ready=1. On i_req_valid at edge T, capture address, write, write_data and strobe.
  - Hit means i_req_address[ADDRESS_WIDTH-1:log2(DATA_WIDTH/8)] equals ADDRESS at the same bits. Low bits are ignored.
  - Hit with the direction permitted by READABLE/WRITABLE -> ACCESS.
  - Hit with the direction not permitted -> RESPONSE, status SLVERR.
  - Miss -> RESPONSE, status DECERR.
- ACCESS lasts exactly one cycle (T+1):
  - o_field_valid=1.
  - Masks and write data are driven from registered copies, never combinationally from the request.
  - A read samples i_field_read_data at the closing edge into the read-data register. This is the pre-side-effect value.
  - Then -> RESPONSE, status OKAY.
- RESPONSE: o_rsp_valid=1 from T+2. Outputs are held stable until i_rsp_ready, then -> IDLE. o_rsp_valid falls the next cycle.
- o_req_ready is low in ACCESS and RESPONSE, so there is no back-to-back overlap. Minimum request-to-request spacing is 3 cycles with i_rsp_ready held high.
- A write with strobe all 0 still issues ACCESS with write_mask 0 and returns OKAY.
- o_field_read_mask, o_field_write_mask and o_field_valid are 0 in every state except ACCESS.
- o_field_write_data holds its last value outside ACCESS.
- o_rsp_read_data is 0 for writes, SLVERR and DECERR.
- Reset asserted mid-access or mid-response aborts immediately. No response is produced after release.

Optional Feature:
RGGEN_ACCESS_DRIVER_WAIT_EN
- Defined: adds port i_field_ready (input, 1).
  - ACCESS holds o_field_valid and the masks until i_field_ready=1.
  - Read data is sampled on the edge where valid and ready are both high, then -> RESPONSE.
- Undefined: port absent; ACCESS is always one cycle.

Test Plan:
- Reset, then idle -> o_req_ready=1, o_rsp_valid=0, o_field_valid=0, o_rsp_status=00.
- Read at ADDRESS=0x10, field value 0x0000_00A5 -> o_field_valid pulses 1 cycle at T+1 with read_mask=0xFFFF_FFFF; o_rsp_valid at T+2 with read_data=0xA5, status 00. A w01crs field then reads all ones.
- Write 0x1234_5678, strobe 4'b0101 -> write_mask=0x00FF_00FF, write_data=0x1234_5678, read_mask=0; response read_data=0, status 00.
- Read at 0x14 (miss) -> no o_field_valid; o_rsp_valid at T+1 with status 11. Write with WRITABLE=0 -> status 10, no access.
- Hold i_rsp_ready=0 for 5 cycles -> o_rsp_valid and data stable, o_req_ready=0, new i_req_valid ignored; accepted 1 cycle after i_rsp_ready.
- Assert i_rst_n low during ACCESS -> all outputs 0 asynchronously; after release, state IDLE with no stray response. With WAIT_EN, ready low 3 cycles -> o_field_valid held 4 cycles.
